alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator-side front end for the team's 32-bit combinational ALU (ops ADD/SUB/AND/OR/XOR/NOT).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand/op ports from the FIFO head, then captures result, zero and overflow into a registered response with backpressure.
- Computes signed overflow for ADD/SUB locally, because the ALU's overflow output is tied low.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the command tag echoed on the response.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  4  operation code.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_tag  in  TAG_W  command identifier.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_op  out  4  to ALU op.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero.
- rsp_ovf  out  1  signed overflow (ADD/SUB only).
- rsp_err  out  1  illegal opcode (op ≥ 6).
- rsp_tag  out  TAG_W  echoed tag.
- busy  out  1  FIFO non-empty or rsp_valid.

Behaviour:
Reset (async assert, sync deassert expected upstream):
- FIFO emptied; pointers and count set to 0.
- rsp_valid=0; rsp_result=0, rsp_zero=0, rsp_ovf=0, rsp_err=0, rsp_tag=0.
- State=IDLE.

Command FIFO:
- Push on cmd_valid&&cmd_ready.
- Pop on issue capture (see below).
- Simultaneous push and pop when full is NOT allowed: cmd_ready depends only on full, with no combinational path from rsp_ready.
- Push and pop in the same cycle when non-empty and not full: count unchanged.
- Pointers wrap modulo DEPTH.

ALU drive:
- alu_a, alu_b, alu_op = FIFO head fields, combinational from storage.
- When the FIFO is empty they are driven to 0.

State machine:
- IDLE: if FIFO non-empty and (!rsp_valid || rsp_ready), then CAPTURE at this edge:
  - rsp_result ← alu_result
  - rsp_zero ← alu_zero
  - rsp_tag ← head tag
  - rsp_ovf, rsp_err computed as below
  - rsp_valid ← 1
  - pop the head
- Else if rsp_valid && rsp_ready: rsp_valid ← 0.
- This gives one capture per cycle at full throughput, because a response register drained by rsp_ready can be refilled on the same edge.

Latency:
- Command accepted at edge N into an empty FIFO → rsp_valid=1 after edge N+1.
- Back-to-back sustained rate: one response per cycle while rsp_ready=1.

Response hold:
- All rsp_* fields are stable while rsp_valid && !rsp_ready.

Overflow:
- op 0 (ADD): ovf = (a[31]==b[31]) && (result[31]!=a[31]).
- op 1 (SUB): ovf = (a[31]!=b[31]) && (result[31]!=a[31]).
- All other ops: ovf = 0.

Illegal op (6..15):
- Still issued and captured.
- rsp_err=1, rsp_result forced to 0, rsp_zero forced to 1, rsp_ovf=0.

Reset mid-operation:
- Buffered commands and the held response are discarded.
- No response is produced for them after reset.

busy: combinational OR of !empty and rsp_valid.

Decomposition:
- Package alu_pkg:
  - op encoding constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_LAST_LEGAL=5.
  - command struct typedef {op, a, b, tag}.
- One natural sub-module: alu_cmd_fifo, a generic synchronous FIFO (DEPTH, width parameters) with full/empty flags.
- Issue/capture logic and overflow computation stay in the top module.
- The bench instantiates the existing ALU connected to the alu_* ports.

Test Plan:
- Single ADD a=0x7FFFFFFF, b=1, tag=3 with rsp_ready=1 → rsp_valid one cycle after acceptance; result=0x80000000, ovf=1, zero=0, tag=3.
- SUB a=5, b=5 → result=0, zero=1, ovf=0. Then SUB a=0x80000000, b=1 → result=0x7FFFFFFF, ovf=1.
- Hold rsp_ready=0 and push 5 commands (DEPTH=4) → cmd_ready drops after 4 FIFO entries plus 1 held response. Release rsp_ready → responses emerge in order, one per cycle, tags intact, all rsp_* fields stable while stalled.
- Illegal op=9, a=0xFFFF, b=1 → rsp_err=1, result=0, zero=1, ovf=0. Next command NOT a=0 → result=0xFFFFFFFF, err=0.
- Streaming: 16 random legal ops with cmd_valid and rsp_ready held high → 16 responses on 16 consecutive cycles, matching a reference model including overflow.
- Assert rst_n low with 3 queued commands and a response pending → all rsp_* fields zero and busy=0 immediately; after release no stale responses appear; a new command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg                                                             |
// | Opcode encoding, command/state types shared by the ALU issuer.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD        = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB        = 4'd1;
    localparam logic [OP_W-1:0] OP_AND        = 4'd2;
    localparam logic [OP_W-1:0] OP_OR         = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR        = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT        = 4'd5;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = 4'd5;

    // ALU-facing part of a command; the issuer pairs it with a tag of its own width
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
    } alu_cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } issue_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_cmd_fifo                                                        |
// | Generic synchronous FIFO with full/empty flags (DEPTH power of 2). |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_cmd_issuer                                                      |
// | Buffers ALU commands, drives the ALU from the FIFO head and        |
// | captures result/zero/overflow into a backpressured response.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    typedef struct packed {
        alu_cmd_t         cmd;
        logic [TAG_W-1:0] tag;
    } fifo_entry_t;

    fifo_entry_t  fifo_wdata;
    fifo_entry_t  head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;

    issue_state_t     state_q, state_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic             capture;
    logic             illegal;
    logic             ovf;

    assign cmd_ready      = !fifo_full;
    assign fifo_push      = cmd_valid && !fifo_full;
    assign fifo_wdata.cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign fifo_wdata.tag = cmd_tag;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign alu_a  = fifo_empty ? '0 : head.cmd.a;
    assign alu_b  = fifo_empty ? '0 : head.cmd.b;
    assign alu_op = fifo_empty ? '0 : head.cmd.op;

    // The ALU ties its overflow low, so signed overflow is derived from operand/result signs
    always_comb begin
        illegal = (head.cmd.op > OP_LAST_LEGAL);
        case (head.cmd.op)
            OP_ADD:  ovf = (head.cmd.a[31] == head.cmd.b[31]) && (alu_result[31] != head.cmd.a[31]);
            OP_SUB:  ovf = (head.cmd.a[31] != head.cmd.b[31]) && (alu_result[31] != head.cmd.a[31]);
            default: ovf = 1'b0;
        endcase
    end

    // A response drained this cycle can be refilled on the same edge
    assign capture = !fifo_empty && ((state_q == ST_IDLE) || rsp_ready);

    always_comb begin
        state_d      = state_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
        fifo_pop     = 1'b0;
        if (capture) begin
            state_d   = ST_RSP;
            fifo_pop  = 1'b1;
            rsp_tag_d = head.tag;
            rsp_err_d = illegal;
            if (illegal) begin
                rsp_result_d = '0;
                rsp_zero_d   = 1'b1;
                rsp_ovf_d    = 1'b0;
            end else begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_ovf_d    = ovf;
            end
        end else if ((state_q == ST_RSP) && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RSP);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;
    assign busy       = !fifo_empty || rsp_valid;

endmodule : alu_cmd_issuer
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_cmd_issuer                                                   |
// | Self-checking bench: directed steps plus random streaming against  |
// | a queue-based reference model, with a stand-in combinational ALU.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_ovf;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // Stand-in for the team ALU; junk on illegal ops so the issuer's forcing is visible
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = ~alu_a;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        e;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    int          hand_cyc[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_res;
    logic        last_zero, last_ovf, last_err;
    logic [3:0]  last_tag;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] tag);
        exp_t   e;
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.tag = tag;
        e.e   = 1'b0;
        e.o   = 1'b0;
        case (op)
            4'd0: begin wide = sa + sb; e.res = wide[31:0]; e.o = (wide > SMAX) || (wide < SMIN); end
            4'd1: begin wide = sa - sb; e.res = wide[31:0]; e.o = (wide > SMAX) || (wide < SMIN); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~a;
            default: begin e.res = 32'd0; e.e = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set: records what the next rising edge will transfer
    task automatic step();
        exp_t e;
        if (cmd_valid && cmd_ready) q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_zero",   64'(rsp_zero),   64'(e.z));
                chk("rsp_ovf",    64'(rsp_ovf),    64'(e.o));
                chk("rsp_err",    64'(rsp_err),    64'(e.e));
                chk("rsp_tag",    64'(rsp_tag),    64'(e.tag));
                last_res = rsp_result; last_zero = rsp_zero; last_ovf = rsp_ovf;
                last_err = rsp_err;    last_tag  = rsp_tag;
                hand_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bit acc = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = cmd_ready;
            step();
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    logic [38:0] snap;
    int          n;
    bit          acc;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rsp",       64'({rsp_result, rsp_zero, rsp_ovf, rsp_err, rsp_tag}), 64'd0);
        chk("reset_alu",       64'({alu_a, alu_op}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD, overflow into the sign bit, one-cycle latency
        rsp_ready = 1'b1;
        send(4'd0, 32'h7FFF_FFFF, 32'd1, 4'd3);
        chk("lat_rsp_valid_early", 64'(rsp_valid), 64'd0);
        chk("head_alu_a",          64'(alu_a),     64'h7FFF_FFFF);
        chk("head_busy",           64'(busy),      64'd1);
        step();
        chk("lat_rsp_valid", 64'(rsp_valid),  64'd1);
        chk("add_result",    64'(rsp_result), 64'h8000_0000);
        chk("add_ovf",       64'(rsp_ovf),    64'd1);
        chk("add_zero",      64'(rsp_zero),   64'd0);
        chk("add_tag",       64'(rsp_tag),    64'd3);
        chk("empty_alu_a",   64'(alu_a),      64'd0);
        drain(n);
        chk("idle_busy", 64'(busy), 64'd0);

        // SUB producing zero, then SUB overflowing negative to positive
        send(4'd1, 32'd5, 32'd5, 4'd1);
        drain(n);
        chk("sub0_result", 64'(last_res),  64'd0);
        chk("sub0_zero",   64'(last_zero), 64'd1);
        chk("sub0_ovf",    64'(last_ovf),  64'd0);
        send(4'd1, 32'h8000_0000, 32'd1, 4'd2);
        drain(n);
        chk("sub1_result", 64'(last_res), 64'h7FFF_FFFF);
        chk("sub1_ovf",    64'(last_ovf), 64'd1);

        // Backpressure: 4 FIFO entries plus one held response
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 5)), rnd_operand(), rnd_operand(), 4'(10 + i));
        chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        snap = {rsp_result, rsp_zero, rsp_ovf, rsp_err, rsp_tag};
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd1; cmd_b = 32'd1; cmd_tag = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_ready", 64'(cmd_ready), 64'd0);
            chk("bp_hold_rsp",   64'({rsp_result, rsp_zero, rsp_ovf, rsp_err, rsp_tag}), 64'(snap));
        end
        cmd_valid = 1'b0;
        drain(n);
        chk("bp_drain_cycles", 64'(n), 64'd5);

        // Illegal opcode, then NOT of zero
        send(4'd9, 32'h0000_FFFF, 32'd1, 4'd5);
        drain(n);
        chk("ill_err",    64'(last_err),  64'd1);
        chk("ill_result", 64'(last_res),  64'd0);
        chk("ill_zero",   64'(last_zero), 64'd1);
        chk("ill_ovf",    64'(last_ovf),  64'd0);
        send(4'd5, 32'd0, 32'd0, 4'd6);
        drain(n);
        chk("not_result", 64'(last_res), 64'hFFFF_FFFF);
        chk("not_err",    64'(last_err), 64'd0);

        // Streaming: 16 random legal ops at full rate
        hand_cyc.delete();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_op = 4'($urandom_range(0, 5)); cmd_a = rnd_operand(); cmd_b = rnd_operand(); cmd_tag = 4'(i);
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                acc = cmd_ready;
                step();
            end
        end
        cmd_valid = 1'b0;
        drain(n);
        chk("stream_count", 64'(hand_cyc.size()), 64'd16);
        if (hand_cyc.size() == 16) chk("stream_span", 64'(hand_cyc[15] - hand_cyc[0]), 64'd15);

        // Reset with 3 queued commands and a pending response
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd2, $urandom, $urandom, 4'(i));
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp",       64'({rsp_result, rsp_zero, rsp_ovf, rsp_err, rsp_tag}), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_quiet", 64'(rsp_valid), 64'd0);
        end
        send(4'd0, 32'd2, 32'd3, 4'd9);
        drain(n);
        chk("post_rst_result", 64'(last_res), 64'd5);
        chk("post_rst_tag",    64'(last_tag), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_cmd_issuer
`default_nettype wire
